// File: rtl/mc_ctrl_fsm_if.sv
// Control bundle between the multi-cycle RV32 control FSM and its datapath.
// master = control FSM side, slave = datapath side.
interface mc_ctrl_fsm_if;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       memReady;

    logic       pcWrite;
    logic       adrSrc;
    logic       memWrite;
    logic       irWrite;
    logic [1:0] resultSrc;
    logic [1:0] aluSrcA;
    logic [1:0] aluSrcB;
    logic [1:0] immSrc;
    logic [2:0] aluControl;
    logic       regWrite;
    logic       instrDone;
    logic       illegal;

    modport master (
        input  op, funct3, funct7b5, zero, memReady,
        output pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA,
               aluSrcB, immSrc, aluControl, regWrite, instrDone, illegal
    );

    modport slave (
        output op, funct3, funct7b5, zero, memReady,
        input  pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA,
               aluSrcB, immSrc, aluControl, regWrite, instrDone, illegal
    );
endinterface

// File: rtl/mc_ctrl_fsm.sv
// Moore control FSM for the multi-cycle RV32 core (lw/sw/R/I/beq/bne).
// Optional memory wait states are enabled with the CTRL_MEM_WAIT_EN macro.
module mc_ctrl_fsm #(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic          clk,
    input  logic          reset,
    mc_ctrl_fsm_if.master bus
);

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        ALUWB    = 4'd7,
        EXECI    = 4'd8,
        BRANCH   = 4'd9,
        TRAP     = 4'd10
    } state_t;

    state_t     state_r;
    state_t     next_state_s;

    logic       pc_write_s;
    logic       adr_src_s;
    logic       mem_write_s;
    logic       ir_write_s;
    logic [1:0] result_src_s;
    logic [1:0] alu_src_a_s;
    logic [1:0] alu_src_b_s;
    logic [2:0] alu_control_s;
    logic       reg_write_s;
    logic       instr_done_s;
    logic       illegal_s;
    logic       mem_ready_s;

    // ALU operation for R/I types; sub only for R-type with inst[30] set
    function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                              input logic       f7b5,
                                              input logic       op5);
        logic [2:0] ctl;
        case (f3)
            3'b000:  ctl = (f7b5 & op5) ? 3'b001 : 3'b000;
            3'b010:  ctl = 3'b101;
            3'b110:  ctl = 3'b011;
            3'b111:  ctl = 3'b010;
            default: ctl = 3'b000;
        endcase
        return ctl;
    endfunction

    function automatic logic [1:0] imm_decode(input logic [6:0] opc);
        logic [1:0] sel;
        case (opc)
            7'b0100011: sel = 2'b10;
            7'b1100011: sel = 2'b11;
            default:    sel = 2'b00;
        endcase
        return sel;
    endfunction

    function automatic logic rf_funct_bad(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b011) || (f3 == 3'b100) || (f3 == 3'b101);
    endfunction

`ifdef CTRL_MEM_WAIT_EN
    assign mem_ready_s = bus.memReady;
`else
    logic unused_mem_ready_s;
    assign unused_mem_ready_s = bus.memReady;
    assign mem_ready_s        = 1'b1;
`endif

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= state_t'(RESET_STATE);
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state and Moore output decode
    always_comb begin
        next_state_s  = FETCH;
        pc_write_s    = 1'b0;
        adr_src_s     = 1'b0;
        mem_write_s   = 1'b0;
        ir_write_s    = 1'b0;
        result_src_s  = 2'b00;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        alu_control_s = 3'b000;
        reg_write_s   = 1'b0;
        instr_done_s  = 1'b0;
        illegal_s     = 1'b0;

        case (state_r)
            FETCH: begin
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
                ir_write_s   = mem_ready_s;
                pc_write_s   = mem_ready_s;
                next_state_s = mem_ready_s ? DECODE : FETCH;
            end
            DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
                case (bus.op)
                    7'b0000011, 7'b0100011: next_state_s = MEMADR;
                    7'b0110011: next_state_s = rf_funct_bad(bus.funct3) ? TRAP : EXECR;
                    7'b0010011: next_state_s = rf_funct_bad(bus.funct3) ? TRAP : EXECI;
                    7'b1100011: next_state_s = (bus.funct3[2:1] == 2'b00) ? BRANCH : TRAP;
                    default:    next_state_s = TRAP;
                endcase
            end
            MEMADR: begin
                alu_src_a_s  = 2'b10;
                alu_src_b_s  = 2'b01;
                next_state_s = bus.op[5] ? MEMWRITE : MEMREAD;
            end
            MEMREAD: begin
                adr_src_s    = 1'b1;
                next_state_s = mem_ready_s ? MEMWB : MEMREAD;
            end
            MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            MEMWRITE: begin
                adr_src_s    = 1'b1;
                mem_write_s  = 1'b1;
                instr_done_s = mem_ready_s;
                next_state_s = mem_ready_s ? FETCH : MEMWRITE;
            end
            EXECR: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = alu_decode(bus.funct3, bus.funct7b5, bus.op[5]);
                next_state_s  = ALUWB;
            end
            EXECI: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_decode(bus.funct3, bus.funct7b5, bus.op[5]);
                next_state_s  = ALUWB;
            end
            ALUWB: begin
                reg_write_s  = 1'b1;
                instr_done_s = 1'b1;
                next_state_s = FETCH;
            end
            BRANCH: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = 3'b001;
                instr_done_s  = 1'b1;
                pc_write_s    = bus.funct3[0] ? ~bus.zero : bus.zero;
                next_state_s  = FETCH;
            end
            TRAP: begin
                illegal_s    = 1'b1;
                next_state_s = TRAP;
            end
            default: begin
                next_state_s = FETCH;
            end
        endcase
    end

    // Write strobes and status are gated off while reset is held
    assign bus.pcWrite    = pc_write_s   & ~reset;
    assign bus.irWrite    = ir_write_s   & ~reset;
    assign bus.memWrite   = mem_write_s  & ~reset;
    assign bus.regWrite   = reg_write_s  & ~reset;
    assign bus.instrDone  = instr_done_s & ~reset;
    assign bus.illegal    = illegal_s    & ~reset;
    assign bus.adrSrc     = adr_src_s;
    assign bus.resultSrc  = result_src_s;
    assign bus.aluSrcA    = alu_src_a_s;
    assign bus.aluSrcB    = alu_src_b_s;
    assign bus.aluControl = alu_control_s;
    assign bus.immSrc     = imm_decode(bus.op);

endmodule

// File: doc/mc_ctrl_fsm.md
Name: mc_ctrl_fsm

Overview:
Main control state machine for the multi-cycle RV32 core. It sequences the shared ALU, memory port, register file and instruction/immediate decoder over several cycles per instruction. It takes opcode, funct fields and the ALU zero flag, and drives every datapath enable and mux select, including the 2-bit immSrc select used by the immediate extender.

Parameters:
RESET_STATE, 4'd0, state entered on reset (FETCH); not to be overridden in the core.

Ports:
clk  input  1  core clock, rising edge
reset  input  1  synchronous, active-high reset
op  input  7  inst[6:0]
funct3  input  3  inst[14:12]
funct7b5  input  1  inst[30]
zero  input  1  ALU zero flag
memReady  input  1  memory completes access this cycle (used only with CTRL_MEM_WAIT_EN)
pcWrite  output  1  PC register load enable
adrSrc  output  1  memory address: 0=PC, 1=ALUOut
memWrite  output  1  data memory write strobe
irWrite  output  1  instruction/oldPC register load
resultSrc  output  2  00=ALUOut, 01=memory data, 10=ALU result
aluSrcA  output  2  00=PC, 01=oldPC, 10=rd1
aluSrcB  output  2  00=rd2, 01=immExt, 10=const 4
immSrc  output  2  00=I, 10=S, 11=B (to extender)
aluControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
regWrite  output  1  register file write enable
instrDone  output  1  one-cycle pulse on the last cycle of each instruction
illegal  output  1  high while in TRAP

Behaviour:
- Moore FSM, 4-bit state register. States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, ALUWB=7, EXECI=8, BRANCH=9, TRAP=10. Codes 11-15 go to FETCH on the next edge.
- Reset: reset high at a rising edge forces state=FETCH. This applies mid-instruction too.
- While reset is high, pcWrite, irWrite, memWrite, regWrite, instrDone and illegal are forced to 0 combinationally.
- Defaults in every state unless listed below: all enables 0, selects 00, aluControl=000.
- immSrc is decoded from op in all states: sw 0100011→10, branch 1100011→11, otherwise 00.
- FETCH: adrSrc=0, irWrite=1, aluSrcA=00, aluSrcB=10, add, resultSrc=10, pcWrite=1. Next state: DECODE.
- DECODE: aluSrcA=01, aluSrcB=01, add (computes branch target). Next state by op:
  - 0000011 or 0100011 → MEMADR
  - 0110011 → EXECR
  - 0010011 → EXECI
  - 1100011 → BRANCH
  - otherwise → TRAP
- Also TRAP from DECODE:
  - R/I type with funct3 in {001,011,100,101}
  - branch with funct3 not in {000,001}
- MEMADR: aluSrcA=10, aluSrcB=01, add. Next state: MEMREAD for lw (op[5]=0), MEMWRITE for sw.
- MEMREAD: adrSrc=1, resultSrc=00. Next state: MEMWB.
- MEMWB: resultSrc=01, regWrite=1, instrDone=1. Next state: FETCH.
- MEMWRITE: adrSrc=1, resultSrc=00, memWrite=1, instrDone=1. Next state: FETCH.
- EXECR / EXECI: aluSrcA=10, aluSrcB=00 (R) or 01 (I), function-decoded ALU op. Next state: ALUWB.
- Function decode by funct3:
  - 000: sub when funct7b5 & op[5], else add
  - 010: slt
  - 110: or
  - 111: and
- ALUWB: resultSrc=00, regWrite=1, instrDone=1. Next state: FETCH.
- BRANCH: aluSrcA=10, aluSrcB=00, sub, resultSrc=00, instrDone=1. Next state: FETCH.
  - pcWrite = zero for beq (funct3 000).
  - pcWrite = ~zero for bne (funct3 001).
- TRAP: illegal=1, all enables 0. Stays in TRAP until reset.
- Latency (no wait states), in cycles including FETCH: lw 5, sw 4, R 4, I 4, branch 3.

Optional Feature:
CTRL_MEM_WAIT_EN.
- Defined:
  - FETCH holds until memReady=1; irWrite and pcWrite are asserted only in the cycle memReady=1.
  - MEMREAD holds until memReady=1.
  - MEMWRITE keeps memWrite high until memReady=1; instrDone is asserted and the state advances only in that cycle.
  - Reset during a wait returns to FETCH.
- Undefined: memReady is ignored and every state lasts one cycle.

Test Plan:
- Reset held 2 cycles then released, op=0110011 funct3=000 funct7b5=1 → state sequence FETCH, DECODE, EXECR (aluControl=001), ALUWB (regWrite=1, instrDone=1), FETCH; all enables 0 while reset high.
- lw (op=0000011) → 5 cycles; MEMADR aluSrcB=01 immSrc=00; MEMREAD adrSrc=1; MEMWB resultSrc=01 regWrite=1.
- sw (op=0100011) → immSrc=10 throughout; MEMWRITE memWrite=1 for exactly 1 cycle.
- beq with zero=1 → BRANCH pcWrite=1; bne with zero=1 → pcWrite=0; immSrc=11 in both cases.
- op=1111111 → TRAP after DECODE, illegal=1 held for 10 cycles; reset → FETCH and illegal=0.
- CTRL_MEM_WAIT_EN, memReady low 3 cycles in FETCH → irWrite/pcWrite pulse only on the memReady cycle; assert reset during a MEMREAD wait → FETCH next edge.
